instruction_fetch: RTL

Fetch/sequencing stage of the single-cycle-memory bbtron core. Sits directly upstream of the instruction memory: drives its 10-bit word address, latches the returned 32-bit word into an instruction register, and presents it to decode/execute one instruction at a time. Owns the program counter, resolves jump/branch targets, stalls on the `in` opcode until the operator confirms input, and stops permanently on `hlt`.

---
 rtl/bbtron_pkg.sv | 29 ++
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch_rise_detect.sv | 27 ++
 rtl/instruction_fetch.sv | 86 ++++++++
 4 files changed

// File: rtl/bbtron_pkg.sv
// Shared bbtron definitions: widths, opcode encodings, opcode field position,
// and the fetch-stage state type.
package bbtron_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;

  typedef logic [OP_MSB-OP_LSB:0] opcode_t;

  localparam opcode_t OP_J   = 6'b010111;
  localparam opcode_t OP_BEQ = 6'b001001;
  localparam opcode_t OP_IN  = 6'b010101;
  localparam opcode_t OP_HLT = 6'b011000;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_HALT
  } fetch_state_t;

  function automatic opcode_t get_opcode(input logic [DATA_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage (master) and the memory / decode side (slave).
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = bbtron_pkg::ADDR_W,
  parameter int unsigned DATA_W = bbtron_pkg::DATA_W
);

  logic [DATA_W-1:0] instruction;
  logic              branch_taken;
  logic              input_ack;
  logic [ADDR_W-1:0] addy;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              waiting_input;
  logic              in_commit;
  logic              halted;

  modport master (
    input  instruction, branch_taken, input_ack,
    output addy, ir, ir_valid, waiting_input, in_commit, halted
  );

  modport slave (
    output instruction, branch_taken, input_ack,
    input  addy, ir, ir_valid, waiting_input, in_commit, halted
  );

endinterface

// File: rtl/instruction_fetch_rise_detect.sv
// Synchronises an asynchronous level and emits a one-cycle pulse on 0->1.
// All flops reset to 1 so a level held high through reset is not an edge.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, hist_q;

  // two-flop synchroniser followed by one history flop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= level_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/instruction_fetch.sv
// bbtron fetch/sequencing stage: owns the PC, latches the instruction
// register, resolves j/beq targets, stalls on `in`, stops on `hlt`.
module instruction_fetch
  import bbtron_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ack_rise;
  logic              ir_valid, waiting_input, in_commit, halted;

  rise_detect u_ack_rise (
    .clk_i  (clock),
    .rst_ni (reset),
    .level_i(bus.input_ack),
    .rise_o (ack_rise)
  );

  // state, program counter and instruction register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // next-state, PC update and status outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid      = 1'b0;
    waiting_input = 1'b0;
    in_commit     = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = bus.instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        ir_valid = 1'b1;
        state_d  = S_FETCH;
        unique case (get_opcode(ir_q))
          OP_J:   pc_d = ir_q[ADDR_W-1:0];
          OP_BEQ: pc_d = bus.branch_taken ? ir_q[ADDR_W-1:0] : pc_q + PC_ONE;
          OP_IN:  state_d = S_WAIT_IN;
          OP_HLT: state_d = S_HALT;
          default: pc_d = pc_q + PC_ONE;
        endcase
      end
      S_WAIT_IN: begin
        waiting_input = 1'b1;
        if (ack_rise) begin
          in_commit = 1'b1;
          pc_d      = pc_q + PC_ONE;
          state_d   = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.addy          = pc_q;
  assign bus.ir            = ir_q;
  assign bus.ir_valid      = ir_valid;
  assign bus.waiting_input = waiting_input;
  assign bus.in_commit     = in_commit;
  assign bus.halted        = halted;

endmodule
